// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_e;

    localparam int SRAM_TIMEOUT_DEFAULT = 15;
    localparam int STALL_W              = 16;

    function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard comparator: load in EX whose destination feeds the ID instruction.
module hazard_detect (
    input  logic       ex_mem_read,
    input  logic [4:0] ex_write_reg,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    output logic       load_use
);

    // r0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign load_use = ex_mem_read && (ex_write_reg != 5'd0) &&
                      ((ex_write_reg == id_rs) || (ex_write_reg == id_rt));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: SRAM wait handling, branch redirect and load-use stall.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int SRAM_TIMEOUT = SRAM_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        ex_memRead,
    input  logic [4:0]  ex_writeReg,
    input  logic        mem_memAccess,
    input  logic        mem_branchTrue,
    input  logic        mem_jump,
    input  logic        sram_ready,
    output logic        sram_req,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic        memwb_bubble,
    output logic        sram_timeout,
    output logic [15:0] stall_cnt
);

    localparam int WAIT_W = (SRAM_TIMEOUT < 1) ? 1 : $clog2(SRAM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(SRAM_TIMEOUT);

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               timeout_q, timeout_d;
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

    logic load_use;
    logic timeout_hit;
    logic mem_busy;

    hazard_detect u_hazard (
        .ex_mem_read  (ex_memRead),
        .ex_write_reg (ex_writeReg),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .load_use     (load_use)
    );

    // At the timeout limit a same-cycle sram_ready is deliberately ignored.
    assign timeout_hit = (state_q == ST_MEM_WAIT) && (wait_cnt_q == TIMEOUT_VAL);
    assign mem_busy    = ((state_q == ST_RUN) && mem_memAccess && !sram_ready) ||
                         ((state_q == ST_MEM_WAIT) && (!sram_ready || timeout_hit));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        case (state_q)
            ST_RUN: begin
                wait_cnt_d = '0;
                if (mem_busy) state_d = ST_MEM_WAIT;
            end
            ST_MEM_WAIT: begin
                if (timeout_hit) begin
                    state_d   = ST_ERROR;
                    timeout_d = 1'b1;
                end else if (sram_ready) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_ERROR;
        endcase
    end

    always_comb begin
        sram_req     = 1'b0;
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        exmem_en     = 1'b1;
        memwb_en     = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_flush  = 1'b0;
        memwb_bubble = 1'b0;
        if (reset) begin
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            exmem_flush  = 1'b1;
            memwb_bubble = 1'b1;
        end else if (state_q == ST_ERROR) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else begin
            sram_req = (state_q == ST_MEM_WAIT) || mem_memAccess;
            if (mem_busy) begin
                pc_en        = 1'b0;
                ifid_en      = 1'b0;
                idex_en      = 1'b0;
                exmem_en     = 1'b0;
                memwb_en     = 1'b0;
                memwb_bubble = 1'b1;
            end else if (mem_branchTrue || mem_jump) begin
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
            end else if (load_use) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q != ST_ERROR) && !pc_en) stall_cnt_d = sat_inc(stall_cnt_q);
    end

    assign sram_timeout = timeout_q;
    assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: two instances (default and short timeout) against a reference model.
module tb_pipe_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_writeReg;
    logic       ex_memRead, mem_memAccess, mem_branchTrue, mem_jump, sram_ready;

    logic        req_a, pc_a, ifid_a, idex_a, exmem_a, memwb_a, fifid_a, fidex_a, fexmem_a, bub_a, to_a;
    logic        req_b, pc_b, ifid_b, idex_b, exmem_b, memwb_b, fifid_b, fidex_b, fexmem_b, bub_b, to_b;
    logic [15:0] sc_a, sc_b;
    logic [9:0]  ctl_a, ctl_b;

    int tests = 0;
    int fails = 0;

    int m_mode [2];
    int m_wait [2];
    bit m_to   [2];
    int m_sc   [2];
    int tmo    [2];

    pipe_ctrl dut_a (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .ex_memRead(ex_memRead), .ex_writeReg(ex_writeReg), .mem_memAccess(mem_memAccess),
        .mem_branchTrue(mem_branchTrue), .mem_jump(mem_jump), .sram_ready(sram_ready),
        .sram_req(req_a), .pc_en(pc_a), .ifid_en(ifid_a), .idex_en(idex_a),
        .exmem_en(exmem_a), .memwb_en(memwb_a), .ifid_flush(fifid_a), .idex_flush(fidex_a),
        .exmem_flush(fexmem_a), .memwb_bubble(bub_a), .sram_timeout(to_a), .stall_cnt(sc_a)
    );

    pipe_ctrl #(.SRAM_TIMEOUT(3)) dut_b (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .ex_memRead(ex_memRead), .ex_writeReg(ex_writeReg), .mem_memAccess(mem_memAccess),
        .mem_branchTrue(mem_branchTrue), .mem_jump(mem_jump), .sram_ready(sram_ready),
        .sram_req(req_b), .pc_en(pc_b), .ifid_en(ifid_b), .idex_en(idex_b),
        .exmem_en(exmem_b), .memwb_en(memwb_b), .ifid_flush(fifid_b), .idex_flush(fidex_b),
        .exmem_flush(fexmem_b), .memwb_bubble(bub_b), .sram_timeout(to_b), .stall_cnt(sc_b)
    );

    assign ctl_a = {req_a, pc_a, ifid_a, idex_a, exmem_a, memwb_a, fifid_a, fidex_a, fexmem_a, bub_a};
    assign ctl_b = {req_b, pc_b, ifid_b, idex_b, exmem_b, memwb_b, fifid_b, fidex_b, fexmem_b, bub_b};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Mode: 0 = running, 1 = waiting on SRAM, 2 = faulted. Vector order:
    // {req, pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush, exmem_flush, bubble}
    task automatic check(input int k, input logic [9:0] obs, input logic obs_to, input logic [15:0] obs_sc);
        logic [9:0] e;
        bit lu, hold, rq;
        lu   = ex_memRead && (ex_writeReg != 0) && (ex_writeReg == id_rs || ex_writeReg == id_rt);
        hold = 1'b0;
        rq   = 1'b0;
        if (reset) begin
            e = 10'b0_11111_1111;
        end else if (m_mode[k] == 2) begin
            e = 10'b0;
        end else begin
            if (m_mode[k] == 0) hold = mem_memAccess && !sram_ready;
            else                hold = !sram_ready || (m_wait[k] == tmo[k]);
            rq = (m_mode[k] == 1) || mem_memAccess;
            if (hold)                             e = {rq, 5'b00000, 4'b0001};
            else if (mem_branchTrue || mem_jump)  e = {rq, 5'b11111, 4'b1110};
            else if (lu)                          e = {rq, 5'b00111, 4'b0100};
            else                                  e = {rq, 5'b11111, 4'b0000};
        end

        tests++;
        assert (obs === e) else begin
            fails++;
            $error("FAIL ctl[%0d] observed=%b expected=%b", k, obs, e);
        end
        tests++;
        assert (obs_to === m_to[k]) else begin
            fails++;
            $error("FAIL sram_timeout[%0d] observed=%b expected=%b", k, obs_to, m_to[k]);
        end
        tests++;
        assert (obs_sc === 16'(m_sc[k])) else begin
            fails++;
            $error("FAIL stall_cnt[%0d] observed=%0d expected=%0d", k, obs_sc, m_sc[k]);
        end

        if (reset) begin
            m_mode[k] = 0; m_wait[k] = 0; m_to[k] = 1'b0; m_sc[k] = 0;
        end else begin
            if (m_mode[k] != 2 && !e[8] && m_sc[k] < 65535) m_sc[k]++;
            if (m_mode[k] == 0) begin
                if (hold) begin m_mode[k] = 1; m_wait[k] = 0; end
            end else if (m_mode[k] == 1) begin
                if (m_wait[k] == tmo[k])  begin m_mode[k] = 2; m_to[k] = 1'b1; end
                else if (sram_ready)      begin m_mode[k] = 0; m_wait[k] = 0; end
                else                      m_wait[k]++;
            end
        end
    endtask

    task automatic step(input bit r, input logic [4:0] rs, input logic [4:0] rt, input bit exrd,
                        input logic [4:0] wr, input bit acc, input bit br, input bit jmp, input bit rdy);
        @(negedge clk);
        reset = r; id_rs = rs; id_rt = rt; ex_memRead = exrd; ex_writeReg = wr;
        mem_memAccess = acc; mem_branchTrue = br; mem_jump = jmp; sram_ready = rdy;
        #1;
        check(0, ctl_a, to_a, sc_a);
        check(1, ctl_b, to_b, sc_b);
    endtask

    initial begin
        tmo[0] = 15; tmo[1] = 3;
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0; m_wait[k] = 0; m_to[k] = 1'b0; m_sc[k] = 0;
        end
        reset = 1'b1; id_rs = 0; id_rt = 0; ex_memRead = 0; ex_writeReg = 0;
        mem_memAccess = 0; mem_branchTrue = 0; mem_jump = 0; sram_ready = 0;

        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // load-use on rt, then r0 destination
        step(0, 1, 5, 1, 5, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 3, 1, 0, 0, 0, 0, 0);
        // SRAM wait: one RUN stall cycle, three MEM_WAIT stall cycles, then ready
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // redirect beats load-use
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 2, 2, 1, 2, 0, 1, 0, 0);
        step(0, 7, 1, 1, 7, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // timeout and recovery through reset
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0, 1);
        step(0, 4, 4, 1, 4, 1, 1, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // long wait so the default instance times out too
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 79) == 0),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                 (i < 400) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
